seq_gen: RTL and testbench

Serial bit-pattern transmitter: on a start request it shifts out one of two fixed PAT_W-bit patterns, MSB first, one bit per clock. It repeats the pattern a programmable number of times, with a programmable idle gap between repetitions. It is the stimulus/transmit end for the serial sequence detectors in this design: pattern 0 drives the "001" detector and pattern 1 drives the "110" detector.

---
 rtl/seq_gen.sv | 169 ++++++++++++++++
 tb/tb_seq_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// seq_gen: serial bit-pattern transmitter. On start it shifts out PAT0 or PAT1 MSB first,
// repeated rep_cnt times with gap idle cycles between copies. Define SEQ_GEN_LAST_EN to add the 'last' output.
module seq_gen #(
  parameter int unsigned      PAT_W = 3,
  parameter logic [PAT_W-1:0] PAT0  = PAT_W'(3'b001),
  parameter logic [PAT_W-1:0] PAT1  = PAT_W'(3'b110)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       pat_sel,
  input  logic [3:0] rep_cnt,
  input  logic [3:0] gap,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done
`ifdef SEQ_GEN_LAST_EN
  ,
  output logic       last
`endif
);

  localparam int unsigned      CNT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [PAT_W-1:0] sh, sh_d;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [3:0]       rep_q, rep_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       gap_cnt, gap_cnt_d;
  logic             sel_q, sel_d;
  logic             out_d, valid_d, busy_d, done_d;
`ifdef SEQ_GEN_LAST_EN
  logic             last_d;
`endif

  logic [PAT_W-1:0] reload_pat;
  logic             last_bit;

  // The pattern used for every repetition comes from the selection latched at start.
  assign reload_pat = sel_q ? PAT1 : PAT0;
  assign last_bit   = (bit_cnt == LAST_BIT);

  // Outputs are computed from the current state and registered, so they lag the
  // state register by one edge and never see inputs combinationally.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state;
    sh_d      = sh;
    bit_cnt_d = bit_cnt;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt;
    sel_d     = sel_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef SEQ_GEN_LAST_EN
    last_d    = 1'b0;
`endif

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d   = SHIFT;
            sel_d     = pat_sel;
            sh_d      = pat_sel ? PAT1 : PAT0;
            rep_d     = (rep_cnt == 4'd0) ? 4'd1 : rep_cnt;
            gap_d     = gap;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
          end
        end

        SHIFT: begin
          out_d     = sh[PAT_W-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          sh_d      = sh << 1;
          bit_cnt_d = bit_cnt + 1'b1;
`ifdef SEQ_GEN_LAST_EN
          last_d    = last_bit;
`endif
          if (last_bit) begin
            bit_cnt_d = '0;
            if (rep_q != 4'd0) rep_d = rep_q - 4'd1;
            if (rep_q > 4'd1) begin
              if (gap_q != 4'd0) begin
                state_d   = GAP;
                gap_cnt_d = '0;
              end else begin
                sh_d = reload_pat;
              end
            end else begin
              state_d = DONE;
            end
          end
        end

        GAP: begin
          busy_d    = 1'b1;
          gap_cnt_d = gap_cnt + 4'd1;
          if (gap_cnt == gap_q - 4'd1) begin
            state_d   = SHIFT;
            sh_d      = reload_pat;
            bit_cnt_d = '0;
          end
        end

        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      sel_q   <= 1'b0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GEN_LAST_EN
      last    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_d;
      sh      <= sh_d;
      bit_cnt <= bit_cnt_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gap_cnt <= gap_cnt_d;
      sel_q   <= sel_d;
      out     <= out_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef SEQ_GEN_LAST_EN
      last    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed scenarios plus randomized transmissions
// checked cycle by cycle against a list-based model of the output stream.
module tb_seq_gen;

  localparam int unsigned PAT_W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, pat_sel;
  logic [3:0] rep_cnt, gap;
  logic       out, valid, busy, done;
  logic       last_w;

  int total = 0;
  int bad   = 0;

  // Expected per-cycle vector: {out, valid, busy, done, last}
  logic [4:0] exp_q[$];

  seq_gen #(.PAT_W(PAT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pat_sel (pat_sel),
    .rep_cnt (rep_cnt),
    .gap     (gap),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
`ifdef SEQ_GEN_LAST_EN
    ,
    .last    (last_w)
`endif
  );

`ifndef SEQ_GEN_LAST_EN
  assign last_w = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] obs();
    return {out, valid, busy, done, last_w};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (out,valid,busy,done,last)", tag, got, exp);
    end
  endtask

  // Appends the whole expected stream of one transmission: R copies of the pattern
  // separated by G idle-busy cycles, then a done cycle, then one idle cycle.
  task automatic build(input logic sel, input logic [3:0] rep, input logic [3:0] g);
    logic [PAT_W-1:0] pat;
    int               r;
    logic             lst;
    pat = sel ? 3'b110 : 3'b001;
    r   = (rep == 0) ? 1 : int'(rep);
    for (int i = 0; i < r; i++) begin
      for (int b = 0; b < PAT_W; b++) begin
`ifdef SEQ_GEN_LAST_EN
        lst = (b == PAT_W - 1);
`else
        lst = 1'b0;
`endif
        exp_q.push_back({pat[PAT_W-1-b], 1'b1, 1'b1, 1'b0, lst});
      end
      if (i < r - 1)
        for (int k = 0; k < int'(g); k++) exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00000);
  endtask

  // Starts one transmission from IDLE and checks every cycle until back in IDLE.
  // Inputs are scrambled after acceptance; they must have no effect.
  task automatic run_tx(input logic sel, input logic [3:0] rep, input logic [3:0] g,
                        input string tag);
    exp_q.delete();
    build(sel, rep, g);
    @(negedge clk);
    start = 1'b1; pat_sel = sel; rep_cnt = rep; gap = g;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
      pat_sel = 1'($urandom);
      rep_cnt = 4'($urandom);
      gap     = 4'($urandom);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; pat_sel = 1'b0; rep_cnt = '0; gap = '0;

    // Reset values
    #1;
    check("reset", obs(), 5'b00000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_after_reset", obs(), 5'b00000);
    end

    // Directed scenarios from the functional description
    run_tx(1'b0, 4'd1, 4'd0, "p0_r1_g0");
    run_tx(1'b1, 4'd2, 4'd2, "p1_r2_g2");
    run_tx(1'b0, 4'd0, 4'd5, "p0_r0_g5");
    run_tx(1'b1, 4'd3, 4'd0, "p1_r3_backtoback");
    run_tx(1'b0, 4'd2, 4'd15, "gap_max");
    run_tx(1'b1, 4'd15, 4'd1, "rep_max");

    // Abort during the second bit of a 3-repetition run, then restart at once
    exp_q.delete();
    build(1'b1, 4'd3, 4'd1);
    @(negedge clk);
    start = 1'b1; pat_sel = 1'b1; rep_cnt = 4'd3; gap = 4'd1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1 check("abort_bit1", obs(), exp_q[0]);
    @(posedge clk); #1 check("abort_bit2", obs(), exp_q[1]);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1 check("abort_cleared", obs(), 5'b00000);
    @(negedge clk) abort = 1'b0;
    run_tx(1'b0, 4'd1, 4'd0, "after_abort");

    // Abort wins over a simultaneous start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1; pat_sel = 1'b1; rep_cnt = 4'd1; gap = 4'd0;
    @(posedge clk); #1 check("abort_vs_start", obs(), 5'b00000);
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (2) begin
      @(posedge clk); #1 check("abort_vs_start_idle", obs(), 5'b00000);
    end

    // start held high: next run begins only after done; pat_sel toggling mid-run is ignored
    exp_q.delete();
    build(1'b0, 4'd1, 4'd0);
    build(1'b1, 4'd1, 4'd0);
    @(negedge clk);
    start = 1'b1; pat_sel = 1'b0; rep_cnt = 4'd1; gap = 4'd0;
    @(posedge clk);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      start = (k <= 4);
      if (k < 4) begin
        pat_sel = ~pat_sel; rep_cnt = 4'($urandom); gap = 4'($urandom);
      end else if (k == 4) begin
        pat_sel = 1'b1; rep_cnt = 4'd1; gap = 4'd0;
      end else begin
        pat_sel = 1'($urandom);
      end
      @(posedge clk); #1;
      check($sformatf("held_start[%0d]", k), obs(), exp_q[k]);
    end

    // Asynchronous reset in the middle of a gap
    exp_q.delete();
    build(1'b1, 4'd2, 4'd3);
    @(negedge clk);
    start = 1'b1; pat_sel = 1'b1; rep_cnt = 4'd2; gap = 4'd3;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("pre_rst[%0d]", k), obs(), exp_q[k]);
    end
    #2 rst = 1'b0;
    #1 check("rst_async", obs(), 5'b00000);
    @(posedge clk); #1 check("rst_held", obs(), 5'b00000);
    @(negedge clk) rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1 check("post_rst_idle", obs(), 5'b00000);
    end
    run_tx(1'b0, 4'd2, 4'd1, "after_rst");

    // Randomized transmissions
    for (int n = 0; n < 12; n++) begin
      logic       s;
      logic [3:0] r, g;
      s = 1'($urandom);
      r = 4'($urandom_range(0, 6));
      g = 4'($urandom_range(0, 6));
      run_tx(s, r, g, $sformatf("rand%0d_s%0d_r%0d_g%0d", n, s, r, g));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
